// File: rtl/uart_rx_deframer_if.sv
// Serial line into the UART deframer and the decoded byte/status coming back out.
// The line driver and consumer take the master modport; the deframer takes slave.
interface uart_rx_deframer_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Frame_Err;
  logic       o_Rx_Active;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Frame_Err,
    input  o_Rx_Active
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Frame_Err,
    output o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: mid-bit sampling, byte valid about 9.5 bit times after the start edge.
// No backpressure: each good byte is a single-cycle valid pulse the consumer must take.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_rx_deframer_if.slave  rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          sync_1;
  logic          rx_s;
  logic          dv_q;
  logic          err_q;
  logic          act_q;
  logic [7:0]    byte_q;

  // Flops reset to the idle-high level so a reset never fakes a start edge.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx.i_Rx_Serial;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 3'd0;
      shift  <= 8'h00;
      byte_q <= 8'h00;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              act_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
              idx   <= 3'd0;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_q <= shift;
              dv_q   <= 1'b1;
              state  <= CLEANUP;
            end else begin
              err_q <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: begin
          act_q <= 1'b0;
          state <= IDLE;
        end
        // A bad stop bit is reported once; a held-low break parks here silently.
        WAIT_HIGH: begin
          if (rx_s) begin
            act_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= 3'd0;
          act_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign rx.o_Rx_DV     = dv_q;
  assign rx.o_Frame_Err = err_q;
  assign rx.o_Rx_Active = act_q;
  assign rx.o_Rx_Byte   = byte_q;

endmodule
